// File: rtl/bus_pkg.sv
// Shared bus definitions: system bus widths, master sequencer state encoding
// and the default WAIT-phase timeout.
package bus_pkg;

    localparam int unsigned BUS_ADDR_WIDTH  = 12;
    localparam int unsigned MEM_WIDTH       = 8;
    localparam int unsigned MEM_DEPTH       = 8;
    localparam int unsigned BUS_IO_NUM      = 2;
    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned TMO_CNT_WIDTH   = 8;
    localparam int unsigned ERR_CNT_WIDTH   = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ALE  = 3'd1,
        CMD  = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } bus_state_e;

endpackage

// File: rtl/bus_master_seq_if.sv
// Request/response handshake plus bus-controller CPU-side signals.
//   master : view of bus_master_seq (takes requests, drives the bus strobes)
//   slave  : view of the requester / bus controller environment
interface bus_master_seq_if
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MEM_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  ale_en;
    logic                  bus_read_en;
    logic                  bus_write_en;
    logic [ADDR_WIDTH-1:0] addr_input;
    logic [DATA_WIDTH-1:0] data_write;
    logic [DATA_WIDTH-1:0] data_read;
    logic                  bus_ready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, data_read, bus_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ale_en, bus_read_en, bus_write_en, addr_input, data_write
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, data_read, bus_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ale_en, bus_read_en, bus_write_en, addr_input, data_write
    );

endinterface

// File: rtl/bus_timeout_ctr.sv
// WAIT-phase timeout counter with a saturating count of expired waits.
//   clr        : restart the wait count (entering WAIT)
//   en         : a WAIT cycle without bus_ready
//   at_limit_c : this enabled cycle is the last one before timeout
//   err_count  : number of timeouts, saturating at all-ones
module bus_timeout_ctr
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    output logic                     at_limit_c,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    logic [TMO_CNT_WIDTH-1:0] cnt_q;

    assign at_limit_c = (cnt_q == TMO_CNT_WIDTH'(TIMEOUT - 1));

    // wait counter and saturating timeout tally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            err_count <= '0;
        end else begin
            if (clr) begin
                cnt_q <= '0;
            end else if (en) begin
                cnt_q <= cnt_q + TMO_CNT_WIDTH'(1);
            end
            if (en && at_limit_c && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/bus_master_seq.sv
// Bus initiator: accepts single read/write requests on a valid/ready
// handshake, runs ALE -> CMD -> (WAIT) -> RESP on the bus controller's
// CPU-side interface and returns a one-cycle response pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response handshake and bus-controller signals
//   busy       : sequencer is not IDLE
//   err_count  : saturating count of timed-out transactions
module bus_master_seq
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = MEM_WIDTH,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bus_master_seq_if.master         bus,
    output logic                     busy,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    bus_state_e            state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  rsp_valid_d, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  ale_d, rd_d, wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_out_d;
    logic [DATA_WIDTH-1:0] data_write_d;

    logic                  tmo_clr_c, tmo_en_c, tmo_at_limit_c;

    bus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (tmo_clr_c),
        .en         (tmo_en_c),
        .at_limit_c (tmo_at_limit_c),
        .err_count  (err_count)
    );

    // next state; outputs are decoded from the next state so they register
    // in the same edge the state changes
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        tmo_clr_c   = 1'b0;
        tmo_en_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = ALE;
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end
            ALE: state_d = CMD;
            CMD: begin
                if (bus.bus_ready) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    if (!wr_q) rsp_rdata_d = bus.data_read;
                end else begin
                    state_d   = WAIT;
                    tmo_clr_c = 1'b1;
                end
            end
            WAIT: begin
                // ready on the expiring edge takes priority over the timeout
                if (bus.bus_ready) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    if (!wr_q) rsp_rdata_d = bus.data_read;
                end else begin
                    tmo_en_c = 1'b1;
                    if (tmo_at_limit_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ale_d        = (state_d == ALE);
        rd_d         = (state_d == CMD) && !wr_d;
        wr_en_d      = (state_d == CMD) && wr_d;
        addr_out_d   = ((state_d == ALE) || (state_d == CMD) || (state_d == WAIT)) ? addr_d : '0;
        data_write_d = (((state_d == CMD) || (state_d == WAIT)) && wr_d) ? wdata_d : '0;
    end

    // state, request capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            wr_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            bus.req_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_err      <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.ale_en       <= 1'b0;
            bus.bus_read_en  <= 1'b0;
            bus.bus_write_en <= 1'b0;
            bus.addr_input   <= '0;
            bus.data_write   <= '0;
            busy             <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_q             <= wr_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            bus.req_ready    <= (state_d == IDLE);
            bus.rsp_valid    <= rsp_valid_d;
            bus.rsp_err      <= rsp_err_d;
            bus.rsp_rdata    <= rsp_rdata_d;
            bus.ale_en       <= ale_d;
            bus.bus_read_en  <= rd_d;
            bus.bus_write_en <= wr_en_d;
            bus.addr_input   <= addr_out_d;
            bus.data_write   <= data_write_d;
            busy             <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_bus_master_seq.sv
// Self-checking bench for bus_master_seq: table-driven requests against a
// bus responder with programmable ready delay, scoreboarded responses, and
// hand-written sequences for back-to-back, idle-ready and mid-wait reset.
module tb_bus_master_seq;
    import bus_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;
    localparam int unsigned T  = 16;
    localparam int NEVER = 1000;
    localparam int NVEC  = 8;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            dly;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        int            lat;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [7:0] err_count;

    bus_master_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bus_master_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];
    int model_err = 0;

    logic          hs_write = 1'b0;
    logic [AW-1:0] hs_addr  = '0;
    logic [DW-1:0] hs_wdata = '0;
    int            rdelay   = NEVER;
    logic          rdy_resp = 1'b0;
    logic          rdy_force = 1'b0;
    logic [DW-1:0] mem [4096];

    assign bus.bus_ready = rdy_resp | rdy_force;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // bus controller model: memory plus ready after rdelay WAIT cycles
    initial begin : responder
        int            k;
        logic          act;
        logic [AW-1:0] raddr;
        logic          rwr;
        k = 0; act = 1'b0; raddr = '0; rwr = 1'b0;
        bus.data_read = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 1'b0;
                rdy_resp = 1'b0;
            end else begin
                rdy_resp = 1'b0;
                bus.data_read = DW'($urandom);
                if (bus.bus_read_en || bus.bus_write_en) begin
                    if (bus.bus_write_en) mem[bus.addr_input] = bus.data_write;
                    raddr = bus.addr_input;
                    rwr   = bus.bus_write_en;
                    k     = 0;
                    act   = (rdelay != NEVER);
                end else if (act) begin
                    k++;
                end
                if (act && (k == rdelay)) begin
                    rdy_resp = 1'b1;
                    if (!rwr) bus.data_read = mem[raddr];
                    act = 1'b0;
                end
            end
        end
    end

    // protocol monitor and scoreboard compare
    initial begin : monitor
        logic prev_strobe;
        logic strobe;
        exp_t e;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_strobe = 1'b0;
            end else begin
                strobe = bus.bus_read_en | bus.bus_write_en;
                check("ready_vs_busy", bus.req_ready, !busy);
                check("strobe_excl", bus.bus_read_en & bus.bus_write_en, 0);
                if (strobe) begin
                    check("strobe_len", prev_strobe, 0);
                    check("cmd_addr", bus.addr_input, hs_addr);
                    check("cmd_dir", bus.bus_write_en, hs_write);
                    check("cmd_dw", bus.data_write, hs_write ? hs_wdata : '0);
                end
                if (bus.ale_en) begin
                    check("ale_addr", bus.addr_input, hs_addr);
                    check("ale_dw", bus.data_write, 0);
                    check("ale_strobe", strobe, 0);
                end
                if (busy && !bus.ale_en && !strobe && !bus.rsp_valid) begin
                    check("wait_addr", bus.addr_input, hs_addr);
                    check("wait_dw", bus.data_write, hs_write ? hs_wdata : '0);
                end
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", bus.rsp_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        if (e.err && model_err < 255) model_err++;
                        check("rsp_rdata", bus.rsp_rdata, e.rdata);
                        check("rsp_err", bus.rsp_err, e.err);
                        check("rsp_cycle", cyc, e.at);
                        check("err_count", err_count, model_err);
                        check("rsp_addr0", bus.addr_input, 0);
                        check("rsp_dw0", bus.data_write, 0);
                        check("rsp_strobes", {bus.ale_en, strobe}, 0);
                    end
                end
                prev_strobe = strobe;
            end
        end
    end

    // drive one request from a negedge; returns the handshake cycle index
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int dly, input logic [DW-1:0] exp_rd, input logic exp_err,
                        input int lat, input bit keep_valid, output int h);
        int guard;
        guard = 0;
        h = -1;
        rdelay = dly;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check("hs_timeout", bus.req_ready, 1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        hs_write = w;
        hs_addr  = a;
        hs_wdata = d;
        if (!keep_valid) bus.req_valid = 1'b0;
        @(negedge clk);
        h = cyc;
        sb.push_back('{exp_rd, exp_err, h + lat});
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t vecs [NVEC];
        int h, h1, h2, h3;

        vecs[0] = '{1'b1, 12'h004, 8'hFF, 0,     8'h00, 1'b0, 2};
        vecs[1] = '{1'b0, 12'h004, 8'h00, 2,     8'hFF, 1'b0, 4};
        vecs[2] = '{1'b0, 12'h104, 8'h00, NEVER, 8'h00, 1'b1, 2 + 16};
        vecs[3] = '{1'b1, 12'h104, 8'h3C, 1,     8'h00, 1'b0, 3};
        vecs[4] = '{1'b0, 12'h104, 8'h00, 15,    8'h3C, 1'b0, 17};
        vecs[5] = '{1'b0, 12'h004, 8'h00, 16,    8'hFF, 1'b0, 18};
        vecs[6] = '{1'b1, 12'h0FF, 8'h81, 17,    8'h00, 1'b1, 18};
        vecs[7] = '{1'b0, 12'h004, 8'h00, 0,     8'hFF, 1'b0, 2};

        for (int i = 0; i < 4096; i++) mem[i] = '0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ale", bus.ale_en, 0);
        check("rst_rd", bus.bus_read_en, 0);
        check("rst_wr", bus.bus_write_en, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", bus.addr_input, 0);
        check("rst_dw", bus.data_write, 0);
        check("rst_rdata", bus.rsp_rdata, 0);
        check("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", bus.req_ready, 1);

        // table-driven requests
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].dly,
                 vecs[i].exp_rd, vecs[i].exp_err, vecs[i].lat, 1'b0, h);
            drain();
        end

        // 254 more timeouts: 256 in total must saturate err_count at 255
        for (int i = 0; i < 254; i++) begin
            send(1'b0, AW'(12'h200 + i), 8'h00, NEVER, 8'h00, 1'b1, 2 + 16, 1'b0, h);
            drain();
        end
        check("err_count_sat", err_count, 255);

        // req_valid held high across three requests
        send(1'b1, 12'h001, 8'hAA, 0, 8'h00, 1'b0, 2, 1'b1, h1);
        send(1'b1, 12'h002, 8'h55, 0, 8'h00, 1'b0, 2, 1'b1, h2);
        send(1'b0, 12'h001, 8'h00, 0, 8'hAA, 1'b0, 2, 1'b0, h3);
        check("b2b_gap1", h2 - h1, 4);
        check("b2b_gap2", h3 - h2, 4);
        drain();

        // bus_ready pulsed while idle has no effect
        rdy_force = 1'b1;
        @(negedge clk);
        rdy_force = 1'b0;
        check("idle_ready_busy", busy, 0);
        @(negedge clk);
        check("idle_ready_busy2", busy, 0);
        check("idle_ready_rsp", bus.rsp_valid, 0);

        // reset in the middle of a read's WAIT phase
        send(1'b0, 12'h104, 8'h00, NEVER, 8'h00, 1'b1, 2 + 16, 1'b0, h);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd", bus.bus_read_en, 0);
        check("mid_rst_wr", bus.bus_write_en, 0);
        check("mid_rst_ale", bus.ale_en, 0);
        check("mid_rst_addr", bus.addr_input, 0);
        check("mid_rst_rsp", bus.rsp_valid, 0);
        check("mid_rst_err_count", err_count, 0);
        sb.delete();
        model_err = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);

        // next request after reset completes normally
        send(1'b0, 12'h002, 8'h00, 1, 8'h55, 1'b0, 3, 1'b0, h);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
